// File: rtl/ks_pkg.sv
// ks_pkg: shared types and helpers for the Kogge-Stone word sequencer
package ks_pkg;
  typedef enum logic {S_FIRST, S_MID} ks_seq_state_t;
  function automatic int ks_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/kogge_stone.sv
// kogge_stone: combinational parallel-prefix adder with carry-in and carry-out
module kogge_stone #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  c_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  c_o
);
  logic [DATA_WIDTH-1:0] g, p, gn, pn, cy;
  // prefix tree: after the last level g[i]/p[i] cover bits 0..i, then fold in the carry-in
  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    gn = '0;
    pn = '0;
    for (int d = 1; d < DATA_WIDTH; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < DATA_WIDTH; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    cy = g | (p & {DATA_WIDTH{c_i}});
  end
  assign sum_o = a_i ^ b_i ^ {cy[DATA_WIDTH-2:0], c_i};
  assign c_o = cy[DATA_WIDTH-1];
endmodule

// File: rtl/ks_word_sequencer.sv
// ks_word_sequencer: WORDS x DATA_WIDTH adder streaming LSW first through one kogge_stone; KS_SEQ_SUB_EN adds sub_i (subtract)
module ks_word_sequencer
  import ks_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  c_i,
`ifdef KS_SEQ_SUB_EN
  input  logic                  sub_i,
`endif
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  out_last_o,
  output logic                  c_o,
  output logic                  busy_o
);
  localparam int BW = ks_cnt_w(WORDS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);
  ks_seq_state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic carry_q, accept, last, sub, add_c, add_co;
  logic [DATA_WIDTH-1:0] add_b, add_sum;
`ifdef KS_SEQ_SUB_EN
  logic sub_q;
  assign sub = (state_q == S_FIRST) ? sub_i : sub_q;
  // the operation kind is captured on the first beat and held until the last
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sub_q <= 1'b0;
    else if (accept && state_q == S_FIRST) sub_q <= sub_i;
`else
  assign sub = 1'b0;
`endif
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept = in_valid_i && in_ready_o;
  assign last = (WORDS == 1) || (state_q == S_MID && beat_q == LAST_BEAT);
  assign busy_o = state_q == S_MID;
  assign add_b = b_i ^ {DATA_WIDTH{sub}};
  assign add_c = (state_q == S_MID) ? carry_q : (sub | c_i);
  kogge_stone #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .a_i  (a_i),
    .b_i  (add_b),
    .c_i  (add_c),
    .sum_o(add_sum),
    .c_o  (add_co)
  );
  // next state: an accepted last beat returns to S_FIRST, anything else lands in S_MID
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    if (accept) begin
      state_d = last ? S_FIRST : S_MID;
      beat_d = last ? '0 : beat_q + 1'b1;
    end
  end
  // FSM and beat counter registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_FIRST;
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
    end
  // inter-word carry plus the single-entry output register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      carry_q <= 1'b0;
      out_valid_o <= 1'b0;
      sum_o <= '0;
      c_o <= 1'b0;
      out_last_o <= 1'b0;
    end else if (accept) begin
      carry_q <= add_co;
      out_valid_o <= 1'b1;
      sum_o <= add_sum;
      c_o <= add_co;
      out_last_o <= last;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_ks_word_sequencer.sv
// tb_ks_word_sequencer: randomized self-checking bench against a wide-arithmetic reference model
module tb_ks_word_sequencer;
  localparam int DW = 8;
  localparam int NW = 4;
  localparam int TW = DW * NW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic c = 1'b0;
  logic sub = 1'b0;
  logic [DW-1:0] a = '0, b = '0;
  logic in_ready, out_valid, out_last, co, busy;
  logic [DW-1:0] sum;
  typedef struct packed {logic [DW-1:0] a; logic [DW-1:0] b; logic c; logic s;} beat_t;
  typedef struct packed {logic [DW-1:0] sum; logic last; logic co;} res_t;
  beat_t in_q[$];
  res_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int op_beats = 0;
  int pending = 0;

  ks_word_sequencer #(.DATA_WIDTH(DW), .WORDS(NW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .c_i        (c),
`ifdef KS_SEQ_SUB_EN
    .sub_i      (sub),
`endif
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sum_o      (sum),
    .out_last_o (out_last),
    .c_o        (co),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // whole operation computed as one wide sum, then split into expected result words
  task automatic add_op(input logic [TW-1:0] x, input logic [TW-1:0] y, input logic ci, input logic s);
    logic [TW:0] full;
    beat_t bt;
    res_t r;
`ifndef KS_SEQ_SUB_EN
    s = 1'b0;
`endif
    full = {1'b0, x} + {1'b0, (s ? ~y : y)} + (TW+1)'(s | ci);
    for (int i = 0; i < NW; i++) begin
      bt.a = x[i*DW +: DW];
      bt.b = y[i*DW +: DW];
      bt.c = (i == 0) ? ci : 1'($urandom);
      bt.s = (i == 0) ? s : 1'($urandom);
      in_q.push_back(bt);
      r.sum = full[i*DW +: DW];
      r.last = (i == NW - 1);
      r.co = full[TW];
      exp_q.push_back(r);
    end
  endtask

  task automatic run(input int pv, input int pr, input int max_cycles);
    int cyc;
    logic hold;
    logic [DW-1:0] held;
    cyc = 0;
    hold = 1'b0;
    held = '0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      out_ready = $urandom_range(99) < pr;
      in_valid = in_q.size() > 0 && $urandom_range(99) < pv;
      if (in_q.size() > 0) {a, b, c, sub} = in_q[0];
      else {a, b, c, sub} = {DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom)};
      #1;
      if (hold) check("hold_sum", sum, held);
      check("busy", busy, op_beats != 0);
      check("out_valid", out_valid, pending > 0);
      check("in_ready", in_ready, pending == 0 || out_ready);
      hold = out_valid && !out_ready;
      held = sum;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          check("sum", sum, exp_q[0].sum);
          check("last", out_last, exp_q[0].last);
          if (exp_q[0].last) check("carry_out", co, exp_q[0].co);
          void'(exp_q.pop_front());
        end
        pending--;
      end
      if (in_valid && in_ready) begin
        void'(in_q.pop_front());
        op_beats = (op_beats + 1) % NW;
        pending++;
      end
    end
    check("drained", in_q.size() + exp_q.size(), 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_last", out_last, 0);
    check("rst_co", co, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    add_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    run(100, 100, 50);
    add_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    add_op(32'h00000002, 32'h00000003, 1'b0, 1'b0);
    run(100, 100, 50);
    add_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    run(100, 30, 200);
    add_op(32'h01FF0000, 32'h01010000, 1'b0, 1'b0);
    run(40, 100, 200);
`ifdef KS_SEQ_SUB_EN
    add_op(32'h00000000, 32'h00000001, 1'b0, 1'b1);
    add_op(32'h00000005, 32'h00000003, 1'b1, 1'b1);
    run(100, 100, 50);
`endif
    for (int k = 0; k < 40; k++)
      add_op(TW'($urandom), TW'($urandom), 1'($urandom), 1'($urandom));
    run(70, 70, 5000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b1;
      {a, b, c} = {DW'($urandom), DW'($urandom), 1'b0};
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    op_beats = 0;
    pending = 0;
    add_op(32'h00000001, 32'h00000001, 1'b0, 1'b0);
    run(100, 100, 50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
